// File: rtl/ftdi_tx_packet_arbiter.sv
// Round-robin arbiter that frames byte streams from show-ahead source FIFOs as
// {A,id} header, payload, length trailer, and writes them into the FTDI write FIFO.
module ftdi_tx_packet_arbiter #(
    parameter int NSRC   = 2,
    parameter int MAXLEN = 256
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              enable,
    input  logic [NSRC-1:0]   src_empty,
    input  logic [8*NSRC-1:0] src_dout,
    input  logic [NSRC-1:0]   src_last,
    output logic [NSRC-1:0]   src_rd_en,
    input  logic              wf_full,
    output logic [7:0]        wf_din,
    output logic              wf_wr_en,
    output logic              busy,
    output logic [3:0]        grant_id,
    output logic              trunc_err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;

    state_t      state_q;
    logic [3:0]  lastGrant_q;
    logic [3:0]  grantId_q;
    logic [8:0]  cnt_q;
    logic        busy_q;
    logic        truncErr_q;

    logic        selEmpty;
    logic        selLast;
    logic [7:0]  selByte;
    logic        anyReq;
    logic [3:0]  winner;
    logic        beat;
    logic [8:0]  cntInc;
    logic        atMax;
    logic        truncSet;

    always_comb begin
        selEmpty = 1'b1;
        selLast  = 1'b0;
        selByte  = 8'h00;
        for (int i = 0; i < NSRC; i++) begin
            if (grantId_q == 4'(i)) begin
                selEmpty = src_empty[i];
                selLast  = src_last[i];
                selByte  = src_dout[8*i +: 8];
            end
        end
    end

    // Larger rotation offsets are visited first so the nearest requester after lastGrant_q wins.
    always_comb begin
        anyReq = 1'b0;
        winner = 4'h0;
        for (int k = NSRC; k >= 1; k--) begin
            for (int i = 0; i < NSRC; i++) begin
                if (!src_empty[i] && (((int'(lastGrant_q) + k) % NSRC) == i)) begin
                    anyReq = 1'b1;
                    winner = 4'(i);
                end
            end
        end
    end

    assign beat     = (state_q == PAY) && !selEmpty && !wf_full;
    assign cntInc   = cnt_q + 9'd1;
    assign atMax    = (cntInc == 9'(MAXLEN));
    assign truncSet = beat && atMax && !selLast;

    always_comb begin
        wf_din    = 8'h00;
        wf_wr_en  = 1'b0;
        src_rd_en = '0;
        case (state_q)
            HDR: begin
                wf_din   = {4'hA, grantId_q};
                wf_wr_en = !wf_full;
            end
            PAY: begin
                if (beat) begin
                    wf_din   = selByte;
                    wf_wr_en = 1'b1;
                end
                for (int i = 0; i < NSRC; i++) begin
                    src_rd_en[i] = beat && (grantId_q == 4'(i));
                end
            end
            TRL: begin
                wf_din   = cnt_q[7:0];
                wf_wr_en = !wf_full;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 4'(NSRC - 1);
            grantId_q   <= 4'h0;
            cnt_q       <= 9'd0;
            busy_q      <= 1'b0;
            truncErr_q  <= 1'b0;
        end else begin
            if (truncSet) begin
                truncErr_q <= 1'b1;
            end else if (err_clr) begin
                truncErr_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (enable && anyReq) begin
                        grantId_q <= winner;
                        cnt_q     <= 9'd0;
                        state_q   <= HDR;
                        busy_q    <= 1'b1;
                    end
                end
                HDR: begin
                    if (!wf_full) state_q <= PAY;
                end
                PAY: begin
                    if (beat) begin
                        cnt_q <= cntInc;
                        if (selLast || atMax) state_q <= TRL;
                    end
                end
                TRL: begin
                    if (!wf_full) begin
                        lastGrant_q <= grantId_q;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign grant_id  = grantId_q;
    assign trunc_err = truncErr_q;

endmodule

// File: tb/tb_ftdi_tx_packet_arbiter.sv
// Directed bench for ftdi_tx_packet_arbiter: queue-backed source FIFOs, a write
// FIFO logger and per-scenario tasks with hand-computed frames.
module tb_ftdi_tx_packet_arbiter;

    localparam int NSRC   = 2;
    localparam int MAXLEN = 4;

    logic        clk = 1'b0;
    logic        res_n;
    logic        enable;
    logic [1:0]  src_empty;
    logic [15:0] src_dout;
    logic [1:0]  src_last;
    logic [1:0]  src_rd_en;
    logic        wf_full;
    logic [7:0]  wf_din;
    logic        wf_wr_en;
    logic        busy;
    logic [3:0]  grant_id;
    logic        trunc_err;
    logic        err_clr;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [7:0]  wrLog[$];
    int          wrCyc[$];
    int          cycleCnt = 0;
    int          rdCnt0   = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic [1:0]  rdSeen;
    logic [8:0]  popped;

    ftdi_tx_packet_arbiter #(.NSRC(NSRC), .MAXLEN(MAXLEN)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .enable    (enable),
        .src_empty (src_empty),
        .src_dout  (src_dout),
        .src_last  (src_last),
        .src_rd_en (src_rd_en),
        .wf_full   (wf_full),
        .wf_din    (wf_din),
        .wf_wr_en  (wf_wr_en),
        .busy      (busy),
        .grant_id  (grant_id),
        .trunc_err (trunc_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Source FIFO model and write FIFO logger; outputs sampled on the falling edge.
    initial begin
        src_empty = 2'b11;
        src_dout  = 16'h0;
        src_last  = 2'b00;
        forever begin
            @(negedge clk);
            cycleCnt++;
            rdSeen = src_rd_en;
            if (rdSeen[0]) rdCnt0++;
            if (wf_wr_en === 1'b1) begin
                wrLog.push_back(wf_din);
                wrCyc.push_back(cycleCnt);
            end
            if (wf_full === 1'b1) begin
                checks++;
                if (wf_wr_en !== 1'b0 || src_rd_en !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL full_stall: wr_en=%b rd_en=%b, required 0/00 while wf_full", wf_wr_en, src_rd_en);
                end
            end
            @(posedge clk);
            #1;
            if (rdSeen[0] && q0.size() > 0) popped = q0.pop_front();
            if (rdSeen[1] && q1.size() > 0) popped = q1.pop_front();
            src_empty[0] = (q0.size() == 0);
            src_empty[1] = (q1.size() == 0);
            if (q0.size() > 0) {src_last[0], src_dout[7:0]} = q0[0];
            else {src_last[0], src_dout[7:0]} = 9'h0;
            if (q1.size() > 0) {src_last[1], src_dout[15:8]} = q1[0];
            else {src_last[1], src_dout[15:8]} = 9'h0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clearLog();
        wrLog.delete();
        wrCyc.delete();
        rdCnt0 = 0;
    endtask

    task automatic waitWrites(input int n, input int budget, input string name);
        int left;
        left = budget;
        while (wrLog.size() < n && left > 0) begin
            tick(1);
            left--;
        end
        checks++;
        if (wrLog.size() < n) begin
            errors++;
            $display("[TB] FAIL %s_timeout: writes=%0d, required at least %0d", name, wrLog.size(), n);
        end
    endtask

    task automatic applyReset();
        res_n = 1'b0;
        tick(2);
        res_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        enable  = 1'b1;
        wf_full = 1'b0;
        err_clr = 1'b1;
        res_n   = 1'b0;
        tick(2);
        checks += 5;
        if (wf_wr_en !== 1'b0)   begin errors++; $display("[TB] FAIL rst_wr_en: got %b, required 0", wf_wr_en); end
        if (src_rd_en !== 2'b00) begin errors++; $display("[TB] FAIL rst_rd_en: got %b, required 00", src_rd_en); end
        if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
        if (trunc_err !== 1'b0)  begin errors++; $display("[TB] FAIL rst_trunc: got %b, required 0", trunc_err); end
        if (grant_id !== 4'h0)   begin errors++; $display("[TB] FAIL rst_grant: got %h, required 0", grant_id); end
        clearLog();
        err_clr = 1'b0;
        res_n   = 1'b1;
        tick(6);
        checks += 2;
        if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL idle_busy: got %b, required 0", busy); end
        if (wrLog.size() != 0)  begin errors++; $display("[TB] FAIL idle_writes: got %0d, required 0", wrLog.size()); end
    endtask

    task automatic test_single_packet();
        logic [7:0] exp[$];
        exp = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h03};
        clearLog();
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h22});
        q0.push_back({1'b1, 8'h33});
        tick(15);
        checks++;
        if (wrLog.size() != exp.size()) begin errors++; $display("[TB] FAIL single_len: got %0d, required %0d", wrLog.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= wrLog.size() || wrLog[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL single_byte%0d: got %h, required %h", i, (i < wrLog.size()) ? wrLog[i] : 8'hxx, exp[i]);
            end
        end
        checks += 3;
        if (wrCyc.size() != 5 || wrCyc[4] - wrCyc[0] != 4) begin errors++; $display("[TB] FAIL single_consec: writes=%0d not in 5 consecutive cycles", wrCyc.size()); end
        if (rdCnt0 != 3)        begin errors++; $display("[TB] FAIL single_pops: got %0d, required 3", rdCnt0); end
        if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL single_busy: got %b, required 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp[$];
        exp = '{8'hA0, 8'h10, 8'h01, 8'hA1, 8'h20, 8'h01,
                8'hA0, 8'h11, 8'h01, 8'hA1, 8'h21, 8'h01};
        applyReset();
        clearLog();
        q0.push_back({1'b1, 8'h10});
        q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h20});
        q1.push_back({1'b1, 8'h21});
        tick(30);
        checks++;
        if (wrLog.size() != exp.size()) begin errors++; $display("[TB] FAIL rr_len: got %0d, required %0d", wrLog.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= wrLog.size() || wrLog[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL rr_byte%0d: got %h, required %h", i, (i < wrLog.size()) ? wrLog[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (grant_id !== 4'h1) begin errors++; $display("[TB] FAIL rr_grant: got %h, required 1", grant_id); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        exp = '{8'hA0, 8'h41, 8'h42, 8'h43, 8'h44, 8'h04};
        clearLog();
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b0, 8'h43});
        q0.push_back({1'b1, 8'h44});
        waitWrites(3, 20, "bp_start");
        wf_full = 1'b1;
        tick(5);
        wf_full = 1'b0;
        tick(15);
        checks++;
        if (wrLog.size() != exp.size()) begin errors++; $display("[TB] FAIL bp_len: got %0d, required %0d", wrLog.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= wrLog.size() || wrLog[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL bp_byte%0d: got %h, required %h", i, (i < wrLog.size()) ? wrLog[i] : 8'hxx, exp[i]);
            end
        end
        if (wrCyc.size() == 6) begin
            checks += 2;
            if (wrCyc[5] - wrCyc[0] != 10) begin errors++; $display("[TB] FAIL bp_span: got %0d, required 10", wrCyc[5] - wrCyc[0]); end
            if (wrCyc[3] - wrCyc[2] != 6)  begin errors++; $display("[TB] FAIL bp_gap: got %0d, required 6", wrCyc[3] - wrCyc[2]); end
        end
        checks += 2;
        if (rdCnt0 != 4)          begin errors++; $display("[TB] FAIL bp_pops: got %0d, required 4", rdCnt0); end
        if (trunc_err !== 1'b0)   begin errors++; $display("[TB] FAIL bp_trunc: got %b, required 0", trunc_err); end
    endtask

    task automatic test_truncation();
        logic [7:0] exp[$];
        exp = '{8'hA0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h04, 8'hA0, 8'hB5, 8'hB6, 8'h02};
        clearLog();
        for (int i = 1; i <= 6; i++) q0.push_back({(i == 6), 8'hB0 + 8'(i)});
        waitWrites(6, 30, "trunc_first");
        checks++;
        if (trunc_err !== 1'b1) begin errors++; $display("[TB] FAIL trunc_set: got %b, required 1", trunc_err); end
        tick(20);
        checks++;
        if (wrLog.size() != exp.size()) begin errors++; $display("[TB] FAIL trunc_len: got %0d, required %0d", wrLog.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= wrLog.size() || wrLog[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL trunc_byte%0d: got %h, required %h", i, (i < wrLog.size()) ? wrLog[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (trunc_err !== 1'b1) begin errors++; $display("[TB] FAIL trunc_sticky: got %b, required 1", trunc_err); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++;
        if (trunc_err !== 1'b0) begin errors++; $display("[TB] FAIL trunc_clr: got %b, required 0", trunc_err); end
    endtask

    task automatic test_enable_and_reset();
        logic [7:0] exp[$];
        exp = '{8'hA0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h04};
        clearLog();
        q0.push_back({1'b0, 8'hD1});
        q0.push_back({1'b0, 8'hD2});
        q0.push_back({1'b0, 8'hD3});
        q0.push_back({1'b1, 8'hD4});
        q0.push_back({1'b0, 8'hE1});
        q0.push_back({1'b0, 8'hE2});
        q0.push_back({1'b1, 8'hE3});
        waitWrites(2, 20, "en_start");
        enable = 1'b0;
        tick(20);
        checks++;
        if (wrLog.size() != exp.size()) begin errors++; $display("[TB] FAIL en_len: got %0d, required %0d", wrLog.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= wrLog.size() || wrLog[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL en_byte%0d: got %h, required %h", i, (i < wrLog.size()) ? wrLog[i] : 8'hxx, exp[i]);
            end
        end
        checks += 2;
        if (q0.size() != 3) begin errors++; $display("[TB] FAIL en_left: got %0d, required 3", q0.size()); end
        if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL en_busy: got %b, required 0", busy); end

        clearLog();
        enable = 1'b1;
        waitWrites(2, 20, "rst_mid");
        res_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL mid_busy: got %b, required 0", busy); end
        if (wf_wr_en !== 1'b0)   begin errors++; $display("[TB] FAIL mid_wr_en: got %b, required 0", wf_wr_en); end
        if (src_rd_en !== 2'b00) begin errors++; $display("[TB] FAIL mid_rd_en: got %b, required 00", src_rd_en); end
        if (grant_id !== 4'h0)   begin errors++; $display("[TB] FAIL mid_grant: got %h, required 0", grant_id); end
        enable = 1'b0;
        tick(2);
        res_n = 1'b1;
        tick(3);
        checks += 2;
        if (q0.size() != 2)     begin errors++; $display("[TB] FAIL mid_left: got %0d, required 2", q0.size()); end
        if (wrLog.size() != 2)  begin errors++; $display("[TB] FAIL mid_writes: got %0d, required 2", wrLog.size()); end

        exp = '{8'hA0, 8'hE2, 8'hE3, 8'h02};
        clearLog();
        enable = 1'b1;
        tick(15);
        checks++;
        if (wrLog.size() != exp.size()) begin errors++; $display("[TB] FAIL resume_len: got %0d, required %0d", wrLog.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= wrLog.size() || wrLog[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL resume_byte%0d: got %h, required %h", i, (i < wrLog.size()) ? wrLog[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    initial begin
        res_n   = 1'b0;
        enable  = 1'b0;
        wf_full = 1'b0;
        err_clr = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_enable_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
